imem_program_loader: RTL and testbench

- Writer side of the instruction path. It receives a byte stream (e.g. from the UART receiver), packs the bytes into 32-bit MIPS instruction words, and writes them to sequential instruction-memory word addresses.
- Instruction fetch then reads those words and feeds opcode/function fields to the decode controller.
- While a load is in progress, the block holds the CPU in reset.
- Each load is framed by a length header and an XOR checksum trailer, with a per-byte timeout.

---
 rtl/imem_program_loader.sv | 141 ++++++++++++++
 tb/tb_imem_program_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Packs a framed big-endian byte stream into 32-bit words and writes them to instruction memory.
// Write strobe 1 cycle after a word's 4th byte; byte_ready drops in IDLE/WRITE/DONE/ERR.
module imem_program_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] CHK   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]     CAP     = 32'(1) << ADDR_W;

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [23:0]   shift;
  logic [15:0]   len;
  logic [16:0]   word_cnt;
  logic [31:0]   xor_acc;
  logic [TW-1:0] to_cnt;

  logic          fire;
  logic [31:0]   word_in;
  logic [15:0]   hdr;

  assign byte_ready = (state == LEN) || (state == DATA) || (state == CHK);
  assign fire       = byte_valid && byte_ready;
  assign word_in    = {shift, byte_data};
  assign hdr        = {shift[7:0], byte_data};
  assign busy       = (state != IDLE);
  assign cpu_hold   = busy;
  assign imem_we    = (state == WRITE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
      len        <= 16'd0;
      word_cnt   <= 17'd0;
      xor_acc    <= 32'd0;
      to_cnt     <= '0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            word_cnt <= 17'd0;
            imem_addr <= '0;
            xor_acc  <= 32'd0;
            to_cnt   <= '0;
            byte_cnt <= 2'd0;
            len      <= 16'd0;
            state    <= LEN;
          end
        end
        LEN, DATA, CHK: begin
          // An accepted byte always wins over an expiring timeout.
          if (fire) begin
            to_cnt   <= '0;
            shift    <= {shift[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (state == LEN) begin
              if (byte_cnt == 2'd1) begin
                byte_cnt <= 2'd0;
                len      <= hdr;
                if (hdr == 16'd0) begin
                  state <= CHK;
                end else if ({16'd0, hdr} > CAP) begin
                  state    <= ERR;
                  error    <= 1'b1;
                  err_code <= 2'b01;
                end else begin
                  state <= DATA;
                end
              end
            end else if (state == DATA) begin
              if (byte_cnt == 2'd3) begin
                imem_wdata <= word_in;
                state      <= WRITE;
              end
            end else if (byte_cnt == 2'd3) begin
              if (word_in == xor_acc) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= ERR;
                error    <= 1'b1;
                err_code <= 2'b10;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            state    <= ERR;
            error    <= 1'b1;
            err_code <= 2'b11;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        WRITE: begin
          xor_acc   <= xor_acc ^ imem_wdata;
          word_cnt  <= word_cnt + 17'd1;
          // Address wraps naturally after the last word of a full-capacity load.
          imem_addr <= imem_addr + ADDR_W'(1);
          state     <= (word_cnt + 17'd1 == {1'b0, len}) ? CHK : DATA;
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with small capacity and timeout.
module tb_imem_program_loader;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, imem_we, busy, cpu_hold, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [1:0]        err_code;

  imem_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frame_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Record every write strobe; one entry per strobed cycle.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wa_q.push_back(32'(imem_addr));
      wd_q.push_back(imem_wdata);
      check("rdy_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic check_zero_outputs();
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  32'(imem_addr),  32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_hold",  32'(cpu_hold),   32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    check("rst_code",  32'(err_code),   32'd0);
    check("rst_rdy",   32'(byte_ready), 32'd0);
  endtask

  task automatic start_load();
    wa_q.delete(); wd_q.delete(); exp_a.delete(); exp_d.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge right after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) check("rdy_wait", 32'(byte_ready), 32'd1);
    @(negedge clock);
  endtask

  task automatic run_frame(input int max_gap, input int start_at);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(frame_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      start = 1'b0;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("busy_wait", 32'(busy), 32'd0);
  endtask

  task automatic verify_writes();
    check("wr_count", 32'(wa_q.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      check($sformatf("wr_addr%0d", i), wa_q[i], exp_a[i]);
      check($sformatf("wr_data%0d", i), wd_q[i], exp_d[i]);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [1:0] c);
    check({tag, "_done"}, 32'(done),     32'(d));
    check({tag, "_err"},  32'(error),    32'(e));
    check({tag, "_code"}, 32'(err_code), 32'(c));
    check({tag, "_busy"}, 32'(busy),     32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clock);
    check_zero_outputs();
    reset = 1'b0;
    @(negedge clock);

    // Two-word load, with write latency checked on the first word
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h00, 0); send_byte(8'h43, 0); send_byte(8'h08, 0); send_byte(8'h20, 0);
    check("lat_we",   32'(imem_we),    32'd1);
    check("lat_addr", 32'(imem_addr),  32'd0);
    check("lat_data", imem_wdata,      32'h00430820);
    frame_q = {8'h8C, 8'h08, 8'h00, 8'h04, 8'h8C, 8'h4B, 8'h08, 8'h24};
    run_frame(0, -1);
    wait_idle();
    exp_a = {32'd0, 32'd1}; exp_d = {32'h00430820, 32'h8C080004};
    verify_writes();
    check_status("two_word", 1'b1, 1'b0, 2'b00);

    // Bad checksum: words still written
    start_load();
    check("start_clr_done", 32'(done), 32'd0);
    frame_q = {8'h00, 8'h02, 8'h00, 8'h43, 8'h08, 8'h20, 8'h8C, 8'h08, 8'h00, 8'h04,
               8'h8C, 8'h4B, 8'h08, 8'h25};
    run_frame(0, -1);
    wait_idle();
    exp_a = {32'd0, 32'd1}; exp_d = {32'h00430820, 32'h8C080004};
    verify_writes();
    check_status("bad_chk", 1'b0, 1'b1, 2'b10);

    // Length overflow: 5 words into a 4-word memory
    start_load();
    send_byte(8'h00, 0); send_byte(8'h05, 0);
    byte_valid = 1'b0;
    check("ovf_err_now",  32'(error),    32'd1);
    check("ovf_code_now", 32'(err_code), 32'd1);
    wait_idle();
    verify_writes();
    check_status("ovf", 1'b0, 1'b1, 2'b01);

    // Full capacity: 4 words, address wraps back to 0
    start_load();
    frame_q = {8'h00, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
               8'h44, 8'h44, 8'h44, 8'h44, 8'h88, 8'h88, 8'h88, 8'h88,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, -1);
    wait_idle();
    exp_a = {32'd0, 32'd1, 32'd2, 32'd3};
    exp_d = {32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};
    verify_writes();
    check_status("full", 1'b1, 1'b0, 2'b00);
    check("full_addr_wrap", 32'(imem_addr), 32'd0);

    // Zero-length load: only a zero checksum
    start_load();
    frame_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(0, -1);
    wait_idle();
    verify_writes();
    check_status("zero_len", 1'b1, 1'b0, 2'b00);

    // Timeout after a partial word
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h43, 0);
    byte_valid = 1'b0;
    n = 0;
    while (!error && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    wait_idle();
    verify_writes();
    check_status("timeout", 1'b0, 1'b1, 2'b11);

    // Backpressure with random gaps and a start pulse mid-load
    start_load();
    frame_q = {8'h00, 8'h02, 8'h00, 8'h43, 8'h08, 8'h20, 8'h8C, 8'h08, 8'h00, 8'h04,
               8'h8C, 8'h4B, 8'h08, 8'h24};
    run_frame(3, 5);
    wait_idle();
    exp_a = {32'd0, 32'd1}; exp_d = {32'h00430820, 32'h8C080004};
    verify_writes();
    check_status("bp", 1'b1, 1'b0, 2'b00);

    // Reset mid-word, with start held during reset, then a clean reload
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h43, 0);
    byte_valid = 1'b0;
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    check_zero_outputs();
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("rst_start_ign", 32'(busy), 32'd0);
    start_load();
    frame_q = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(0, -1);
    wait_idle();
    exp_a = {32'd0}; exp_d = {32'hDEADBEEF};
    verify_writes();
    check_status("reload", 1'b1, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
